// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - mode/sequencing controller for the wall-clock counter chain
// Drives the counter enables/direction/clear, the set-mode FSM, the idle timeout and field blinking.
module clock_set_ctrl #(
   parameter int BLINK_DIV = 25_000_000,
   parameter int TIMEOUT_S = 10
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_sec_roll,
   input  logic       i_min_roll,
   output logic       o_sec_ena,
   output logic       o_min_ena,
   output logic       o_hr_ena,
   output logic       o_inc,
   output logic       o_sec_clr,
   output logic [1:0] o_mode,
   output logic       o_blank_hr,
   output logic       o_blank_min,
   output logic       o_blank_sec
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [7:0] TO_VAL = 8'(TIMEOUT_S);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    to_cnt_q, to_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic          sec_ena_q, sec_ena_d;
   logic          min_ena_q, min_ena_d;
   logic          hr_ena_q, hr_ena_d;
   logic          inc_q, inc_d;
   logic          sec_clr_q, sec_clr_d;
   logic          blank_hr_q, blank_hr_d;
   logic          blank_min_q, blank_min_d;
   logic          blank_sec_q, blank_sec_d;
   logic          edit;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_RUN;
         to_cnt_q    <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         sec_ena_q   <= 1'b0;
         min_ena_q   <= 1'b0;
         hr_ena_q    <= 1'b0;
         inc_q       <= 1'b1;
         sec_clr_q   <= 1'b0;
         blank_hr_q  <= 1'b0;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         sec_ena_q   <= sec_ena_d;
         min_ena_q   <= min_ena_d;
         hr_ena_q    <= hr_ena_d;
         inc_q       <= inc_d;
         sec_clr_q   <= sec_clr_d;
         blank_hr_q  <= blank_hr_d;
         blank_min_q <= blank_min_d;
         blank_sec_q <= blank_sec_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      sec_ena_d   = 1'b0;
      min_ena_d   = 1'b0;
      hr_ena_d    = 1'b0;
      inc_d       = 1'b1;
      sec_clr_d   = 1'b0;

      // A single up or down press in a set state, not shadowed by a mode press.
      edit = (state_q != ST_RUN) && !i_btn_mode && (i_btn_up ^ i_btn_down);

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
      if (i_btn_mode || edit) begin
         phase_d = 1'b0;
      end

      if (i_btn_mode) begin
         state_d  = state_t'(state_q + 2'd1);
         to_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               sec_ena_d = i_tick;
               min_ena_d = i_tick & i_sec_roll;
               hr_ena_d  = i_tick & i_sec_roll & i_min_roll;
            end
            ST_SET_HR: begin
               hr_ena_d = edit;
               inc_d    = edit ? i_btn_up : 1'b1;
            end
            ST_SET_MIN: begin
               min_ena_d = edit;
               inc_d     = edit ? i_btn_up : 1'b1;
            end
            ST_SET_SEC: begin
               sec_ena_d = edit;
               sec_clr_d = edit;
            end
            default: ;
         endcase

         // An accepted edit outranks a timeout tick in the same cycle.
         if (edit) begin
            to_cnt_d = '0;
         end else if (state_q != ST_RUN && i_tick) begin
            if (to_cnt_q + 8'd1 == TO_VAL) begin
               state_d  = ST_RUN;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
      end

      blank_hr_d  = (state_d == ST_SET_HR)  & phase_d;
      blank_min_d = (state_d == ST_SET_MIN) & phase_d;
      blank_sec_d = (state_d == ST_SET_SEC) & phase_d;
   end

   assign o_sec_ena   = sec_ena_q;
   assign o_min_ena   = min_ena_q;
   assign o_hr_ena    = hr_ena_q;
   assign o_inc       = inc_q;
   assign o_sec_clr   = sec_clr_q;
   assign o_mode      = state_q;
   assign o_blank_hr  = blank_hr_q;
   assign o_blank_min = blank_min_q;
   assign o_blank_sec = blank_sec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed vector bench for clock_set_ctrl
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, b_mode = 1'b0, b_up = 1'b0, b_down = 1'b0;
   logic       sec_roll = 1'b0, min_roll = 1'b0;
   logic       sec_ena, min_ena, hr_ena, inc, sec_clr;
   logic [1:0] mode;
   logic       blank_hr, blank_min, blank_sec;

   int checks = 0;
   int errors = 0;

   clock_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_S(3)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick),
      .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_down),
      .i_sec_roll(sec_roll), .i_min_roll(min_roll),
      .o_sec_ena(sec_ena), .o_min_ena(min_ena), .o_hr_ena(hr_ena),
      .o_inc(inc), .o_sec_clr(sec_clr), .o_mode(mode),
      .o_blank_hr(blank_hr), .o_blank_min(blank_min), .o_blank_sec(blank_sec)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       m, u, d, t, sr, mr;
      logic [1:0] emode;
      logic       es, em, eh, ei, ec;
   } vec_t;

   function automatic vec_t mkv(input logic m, u, d, t, sr, mr,
                                input logic [1:0] emode,
                                input logic es, em, eh, ei, ec);
      vec_t v;
      v = '{m, u, d, t, sr, mr, emode, es, em, eh, ei, ec};
      return v;
   endfunction

   // {mode, sec_ena, min_ena, hr_ena, inc, sec_clr}
   function automatic logic [6:0] outs();
      return {mode, sec_ena, min_ena, hr_ena, inc, sec_clr};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input logic m, u, d, t, sr, mr);
      b_mode = m; b_up = u; b_down = d; tick = t; sec_roll = sr; min_roll = mr;
      @(posedge clk);
      #1;
      b_mode = 0; b_up = 0; b_down = 0; tick = 0; sec_roll = 0; min_roll = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[23];

   initial begin
      int last_t, ntog, n;
      logic prev;

      tbl[0]  = mkv(0,0,0,1,0,0, 2'd0, 1,0,0,1,0);
      tbl[1]  = mkv(0,0,0,0,0,0, 2'd0, 0,0,0,1,0);
      tbl[2]  = mkv(0,0,0,1,0,0, 2'd0, 1,0,0,1,0);
      tbl[3]  = mkv(0,0,0,1,0,0, 2'd0, 1,0,0,1,0);
      tbl[4]  = mkv(0,0,0,1,1,0, 2'd0, 1,1,0,1,0);
      tbl[5]  = mkv(0,0,0,1,1,1, 2'd0, 1,1,1,1,0);
      tbl[6]  = mkv(0,1,0,0,0,0, 2'd0, 0,0,0,1,0);
      tbl[7]  = mkv(0,0,1,0,1,1, 2'd0, 0,0,0,1,0);
      tbl[8]  = mkv(1,0,0,0,0,0, 2'd1, 0,0,0,1,0);
      tbl[9]  = mkv(0,1,0,0,0,0, 2'd1, 0,0,1,1,0);
      tbl[10] = mkv(0,0,1,0,0,0, 2'd1, 0,0,1,0,0);
      tbl[11] = mkv(0,1,1,0,0,0, 2'd1, 0,0,0,1,0);
      tbl[12] = mkv(0,0,0,1,1,1, 2'd1, 0,0,0,1,0);
      tbl[13] = mkv(1,0,0,0,0,0, 2'd2, 0,0,0,1,0);
      tbl[14] = mkv(0,1,0,0,0,0, 2'd2, 0,1,0,1,0);
      tbl[15] = mkv(0,0,1,0,0,0, 2'd2, 0,1,0,0,0);
      tbl[16] = mkv(1,0,0,0,0,0, 2'd3, 0,0,0,1,0);
      tbl[17] = mkv(0,1,0,0,0,0, 2'd3, 1,0,0,1,1);
      tbl[18] = mkv(1,1,0,0,0,0, 2'd0, 0,0,0,1,0);
      tbl[19] = mkv(1,0,0,0,0,0, 2'd1, 0,0,0,1,0);
      tbl[20] = mkv(1,0,1,0,0,0, 2'd2, 0,0,0,1,0);
      tbl[21] = mkv(1,0,0,0,0,0, 2'd3, 0,0,0,1,0);
      tbl[22] = mkv(1,0,0,0,0,0, 2'd0, 0,0,0,1,0);

      do_reset();
      check("reset_outs", 8'(outs()), 8'(7'b00_000_10));
      check("reset_blanks", 8'({blank_hr, blank_min, blank_sec}), 8'd0);

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].t, tbl[i].sr, tbl[i].mr);
         checks++;
         if (outs() !== {tbl[i].emode, tbl[i].es, tbl[i].em, tbl[i].eh, tbl[i].ei, tbl[i].ec}) begin
            errors++;
            $display("FAIL vec%0d: got %b expected %b", i, outs(),
                     {tbl[i].emode, tbl[i].es, tbl[i].em, tbl[i].eh, tbl[i].ei, tbl[i].ec});
         end
      end

      // Blinking in SET_MIN: toggles every 4 cycles, hours never blanked.
      step(1,0,0,0,0,0);
      step(1,0,0,0,0,0);
      check("setmin_mode", 8'(mode), 8'd2);
      prev = blank_min; last_t = -1; ntog = 0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         check("blink_hr_off", 8'(blank_hr), 8'd0);
         if (blank_min !== prev) begin
            if (last_t >= 0) check("blink_period", 8'(c - last_t), 8'd4);
            last_t = c;
            ntog++;
         end
         prev = blank_min;
      end
      check("blink_toggles", 8'(ntog >= 5), 8'd1);
      n = 0;
      while (blank_min !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check("blink_reached_blank", 8'(blank_min), 8'd1);
      step(0,1,0,0,0,0);
      check("edit_unblank", 8'({blank_min, min_ena, inc}), 8'b011);
      step(1,0,0,0,0,0);
      step(1,0,0,0,0,0);
      check("run_blanks", 8'({mode, blank_hr, blank_min, blank_sec}), 8'd0);

      // Timeout with no buttons.
      step(1,0,0,0,0,0);
      step(0,0,0,1,0,0);
      step(0,0,0,0,0,0);
      step(0,0,0,1,0,0);
      check("to_after2", 8'(mode), 8'd1);
      step(0,0,0,1,0,0);
      check("to_after3", 8'(mode), 8'd0);

      // An up press restarts the timeout.
      step(1,0,0,0,0,0);
      step(0,0,0,1,0,0);
      step(0,0,0,1,0,0);
      step(0,1,0,0,0,0);
      check("to_up_pulse", 8'({hr_ena, inc}), 8'b11);
      step(0,0,0,1,0,0);
      step(0,0,0,1,0,0);
      check("to_restart2", 8'(mode), 8'd1);
      step(0,0,0,1,0,0);
      check("to_restart3", 8'(mode), 8'd0);

      // Tick that would time out arrives with an up press: press wins.
      step(1,0,0,0,0,0);
      step(0,0,0,1,0,0);
      step(0,0,0,1,0,0);
      step(0,1,0,1,0,0);
      check("to_btn_wins", 8'({mode, hr_ena}), 8'b011);
      step(0,0,0,1,0,0);
      step(0,0,0,1,0,0);
      check("to_btn_wins2", 8'(mode), 8'd1);
      step(0,0,0,1,0,0);
      check("to_btn_wins3", 8'(mode), 8'd0);

      // Asynchronous reset mid-SET_MIN with a pulse in flight.
      step(1,0,0,0,0,0);
      step(1,0,0,0,0,0);
      step(0,0,1,0,0,0);
      check("pre_reset_pulse", 8'({mode, min_ena, inc}), 8'b1010);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", 8'(outs()), 8'(7'b00_000_10));
      check("async_reset_blanks", 8'({blank_hr, blank_min, blank_sec}), 8'd0);
      #2 rst_n = 1'b1;
      step(0,0,0,1,0,0);
      check("post_reset_run", 8'(outs()), 8'(7'b00_100_10));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
